// File: rtl/dist_uart_framer.sv
// dist_uart_framer: converts a binary distance sample to decimal ASCII and
// streams "<digits>mm\r\n" to a UART transmitter over a tx_enable/tx_done handshake.
module dist_uart_framer #(
    parameter int DIST_W = 16,
    parameter int DIGITS = 5,
    parameter int BAUD   = 115200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dist_valid,
    input  logic [DIST_W-1:0] dist_in,
    output logic              busy,
    output logic              frame_done,
    output logic              tx_enable,
    output logic [7:0]        tx_data,
    output logic [19:0]       tx_bps,
    input  logic              tx_done
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(DIST_W + 1);

    function automatic logic [63:0] pow10(input int n);
        pow10 = 64'd1;
        for (int i = 0; i < n; i++) pow10 = pow10 * 64'd10;
    endfunction

    localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

    typedef enum logic [2:0] {IDLE, CONV, ARM, ACK, WAIT, DONE} state_t;
    state_t state, nxt;

    logic [DIST_W-1:0] bin;
    logic [BW-1:0]     bcd, adj;
    logic              ovf;
    logic [CW-1:0]     cnt;
    logic [3:0]        idx;
    logic [3:0]        dig;
    logic              nz;
    logic [7:0]        tx_byte;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = dist_valid ? CONV : IDLE;
            CONV:    nxt = (cnt == CW'(DIST_W - 1)) ? ARM : CONV;
            ARM:     nxt = tx_done ? ACK : ARM;
            ACK:     nxt = tx_done ? ACK : WAIT;
            WAIT:    nxt = !tx_done ? WAIT : (idx == 4'(DIGITS + 3)) ? DONE : ARM;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift.
    always_comb begin
        adj = '0;
        for (int i = 0; i < DIGITS; i++)
            adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end

    // nz: a non-zero digit exists at or before the current position (blanking off).
    always_comb begin
        dig = 4'd0;
        nz  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (4'(i) == idx) dig = bcd[4*(DIGITS-1-i) +: 4];
            if (4'(i) <= idx && bcd[4*(DIGITS-1-i) +: 4] != 4'd0) nz = 1'b1;
        end
        tx_byte = (idx < 4'(DIGITS))     ? (ovf ? 8'h2D : (nz || idx == 4'(DIGITS - 1)) ? 8'h30 + {4'h0, dig} : 8'h20) :
                  (idx < 4'(DIGITS + 2)) ? 8'h6D :
                  (idx == 4'(DIGITS + 2)) ? 8'h0D : 8'h0A;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_enable <= 1'b0;
            tx_data   <= 8'h00;
            bin       <= '0;
            bcd       <= '0;
            ovf       <= 1'b0;
            cnt       <= '0;
            idx       <= 4'd0;
        end else begin
            tx_enable <= (state == ARM) && tx_done;
            if (state == IDLE && dist_valid) begin
                bin <= dist_in;
                bcd <= '0;
                ovf <= 64'(dist_in) > MAX_VAL;
                cnt <= '0;
            end
            if (state == CONV) begin
                {bcd, bin} <= {adj[BW-2:0], bin, 1'b0};
                cnt        <= cnt + CW'(1);
                idx        <= 4'd0;
            end
            if (state == ARM) tx_data <= tx_byte;
            if (state == WAIT && tx_done && idx != 4'(DIGITS + 3)) idx <= idx + 4'd1;
        end
    end

    assign busy       = (state != IDLE) && (state != DONE);
    assign frame_done = (state == DONE);
    assign tx_bps     = 20'(BAUD);
endmodule

// File: tb/tb_dist_uart_framer.sv
// tb_dist_uart_framer: scoreboard bench with a behavioural transmitter per DUT
// (5-digit and 4-digit instances).
`timescale 1ns/1ps
module tb_dist_uart_framer;
    logic        clk = 0, rst = 1, hold = 0;
    logic        dv5 = 0, dv4 = 0;
    logic [15:0] din5 = 0, din4 = 0;
    logic        busy5, fd5, en5, done5, busy4, fd4, en4, done4;
    logic [7:0]  data5, data4;
    logic [19:0] bps5, bps4;
    int          cd5 = 0, cd4 = 0, n_en5 = 0, n_en4 = 0, n_fd5 = 0, n_fd4 = 0;
    int          n_chk = 0, n_pass = 0;
    logic [7:0]  q5[$], q4[$];

    always #10 clk = ~clk;

    assign done5 = !hold && cd5 == 0;
    assign done4 = cd4 == 0;

    dist_uart_framer #(.DIST_W(16), .DIGITS(5), .BAUD(115200)) u5 (
        .clk(clk), .rst(rst), .dist_valid(dv5), .dist_in(din5), .busy(busy5),
        .frame_done(fd5), .tx_enable(en5), .tx_data(data5), .tx_bps(bps5), .tx_done(done5));

    dist_uart_framer #(.DIST_W(16), .DIGITS(4), .BAUD(9600)) u4 (
        .clk(clk), .rst(rst), .dist_valid(dv4), .dist_in(din4), .busy(busy4),
        .frame_done(fd4), .tx_enable(en4), .tx_data(data4), .tx_bps(bps4), .tx_done(done4));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic void push_frame(input int v, input int d);
        logic [7:0] b[$];
        int dv[6];
        int t = v, lim = 1;
        bit lead = 1;
        for (int i = 0; i < d; i++) lim *= 10;
        for (int i = d - 1; i >= 0; i--) begin dv[i] = t % 10; t /= 10; end
        for (int i = 0; i < d; i++) begin
            if (dv[i] != 0 || i == d - 1) lead = 0;
            b.push_back(v >= lim ? 8'h2D : lead ? 8'h20 : 8'(48 + dv[i]));
        end
        b.push_back(8'h6D); b.push_back(8'h6D); b.push_back(8'h0D); b.push_back(8'h0A);
        foreach (b[i]) if (d == 5) q5.push_back(b[i]); else q4.push_back(b[i]);
    endfunction

    // Transmitter models: accept a byte on tx_enable, then stay busy for 6 cycles.
    always @(negedge clk) begin
        if (en5) begin
            n_en5++;
            check("en_while_busy5", done5, 1);
            check("en_with_exp5", 32'(q5.size() > 0), 1);
            if (q5.size() > 0) check("byte5", data5, q5.pop_front());
            cd5 = 6;
        end else if (cd5 > 0) cd5--;
        if (fd5) n_fd5++;
    end

    always @(negedge clk) begin
        if (en4) begin
            n_en4++;
            check("en_while_busy4", done4, 1);
            check("en_with_exp4", 32'(q4.size() > 0), 1);
            if (q4.size() > 0) check("byte4", data4, q4.pop_front());
            cd4 = 6;
        end else if (cd4 > 0) cd4--;
        if (fd4) n_fd4++;
    end

    task automatic send(input bit four, input int v, input bit exp);
        @(negedge clk);
        if (four) begin dv4 = 1; din4 = 16'(v); end
        else begin dv5 = 1; din5 = 16'(v); end
        if (exp) push_frame(v, four ? 4 : 5);
        @(negedge clk);
        dv4 = 0;
        dv5 = 0;
    endtask

    task automatic wait_idle(input bit four);
        int k = 0;
        while ((four ? (busy4 || q4.size() != 0) : (busy5 || q5.size() != 0)) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("frame_timeout", 32'(k < 3000), 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int f, e, k;
        repeat (3) @(negedge clk);
        check("rst_busy", busy5, 0);
        check("rst_frame_done", fd5, 0);
        check("rst_tx_enable", en5, 0);
        check("rst_tx_data", data5, 0);
        check("tx_bps", bps5, 115200);
        rst = 0;
        // 1234 with first-byte latency
        f = n_fd5;
        send(0, 1234, 1);
        k = 1;
        while (!en5 && k < 100) begin @(negedge clk); k++; end
        check("latency", k, 18);
        wait_idle(0);
        check("fd_1234", n_fd5 - f, 1);
        // 0 and 65535
        f = n_fd5;
        send(0, 0, 1);
        wait_idle(0);
        send(0, 65535, 1);
        wait_idle(0);
        check("fd_0_65535", n_fd5 - f, 2);
        // dist_valid during byte 3 is dropped
        f = n_fd5;
        e = n_en5;
        send(0, 1234, 1);
        k = 0;
        while (n_en5 < e + 3 && k < 500) begin @(negedge clk); k++; end
        send(0, 777, 0);
        wait_idle(0);
        check("drop_fd", n_fd5 - f, 1);
        e = n_en5;
        repeat (40) @(negedge clk);
        check("drop_no_frame_busy", busy5, 0);
        check("drop_no_frame_en", n_en5 - e, 0);
        // transmitter stalled on entry to ARM
        hold = 1;
        e = n_en5;
        send(0, 42, 1);
        repeat (520) @(negedge clk);
        check("held_no_en", n_en5 - e, 0);
        check("held_busy", busy5, 1);
        hold = 0;
        @(negedge clk);
        check("en_after_release", en5, 1);
        wait_idle(0);
        // reset during WAIT of byte 5
        f = n_fd5;
        e = n_en5;
        send(0, 1234, 1);
        k = 0;
        while (n_en5 < e + 5 && k < 500) begin @(negedge clk); k++; end
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("midrst_busy", busy5, 0);
        check("midrst_en", en5, 0);
        q5.delete();
        e = n_en5;
        repeat (40) @(negedge clk);
        check("midrst_no_en", n_en5 - e, 0);
        check("midrst_no_fd", n_fd5 - f, 0);
        send(0, 65535, 1);
        wait_idle(0);
        check("after_rst_fd", n_fd5 - f, 1);
        // 4-digit overflow boundary
        f = n_fd4;
        send(1, 10000, 1);
        wait_idle(1);
        send(1, 9999, 1);
        wait_idle(1);
        check("fd4", n_fd4 - f, 2);
        check("bytes4", n_en4, 16);
        check("tx_bps4", bps4, 9600);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
